// File: rtl/imem_banked_loader.sv
// imem_banked_loader: instruction memory with a power-on NOP sweep and a debug burst loader.
// Optional per-word even parity, enabled by defining IMEM_PARITY_EN.
module imem_banked_loader #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 1024,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_addr,
  output logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_data,
  output logic            fetch_fault,
  input  logic            dbg_start,
  input  logic [31:0]     dbg_base,
  input  logic [15:0]     dbg_len,
  input  logic            dbg_wr_valid,
  input  logic [XLEN-1:0] dbg_wr_data,
  output logic            dbg_wr_ready,
  output logic            dbg_done,
`ifdef IMEM_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [1:0]  S_CLEAR    = 2'd0;
  localparam logic [1:0]  S_IDLE     = 2'd1;
  localparam logic [1:0]  S_LOAD     = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [15:0]     rem_q, rem_d;
  logic            done_q, done_d;
  logic            busy_q, wr_ready_q;
  logic            fetch_valid_q, fetch_fault_q;
  logic [XLEN-1:0] fetch_data_q;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            beat, accept, rd_fault;
  logic [AW-1:0]   rd_idx;
  logic            unused_base;

  logic [XLEN-1:0] mem_q [DEPTH];

  assign beat        = dbg_wr_valid && wr_ready_q;
  assign fetch_ready = (state_q == S_IDLE) && !dbg_start;
  assign accept      = fetch_req && fetch_ready;
  assign rd_fault    = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= ADDR_LIMIT);
  assign rd_idx      = fetch_addr[AW+1:2];
  assign unused_base = ^{dbg_base[31:AW+2], dbg_base[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  // Next state, sweep/burst pointers and the shared memory write port.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = sweep_q;
    wdata   = NOP_WORD;
    case (state_q)
      S_CLEAR: begin
        we      = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (dbg_start) begin
          state_d = S_LOAD;
          ptr_d   = dbg_base[AW+1:2];
          rem_d   = (dbg_len == 16'd0) ? 16'd0 : dbg_len - 16'd1;
        end
      end
      S_LOAD: begin
        if (beat) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = dbg_wr_data;
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q       <= '0;
      ptr_q         <= '0;
      rem_q         <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b1;
      wr_ready_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      sweep_q       <= sweep_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      done_q        <= done_d;
      busy_q        <= (state_d != S_IDLE);
      wr_ready_q    <= (state_d == S_LOAD);
      fetch_valid_q <= accept;
      // Fetch outputs hold their last value between accepted requests.
      if (accept) begin
        fetch_fault_q <= rd_fault;
        fetch_data_q  <= rd_fault ? NOP_WORD : mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[waddr] <= wdata;
  end

`ifdef IMEM_PARITY_EN
  logic par_q [DEPTH];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (we && !reset) par_q[waddr] <= ^wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)       parity_err_q <= 1'b0;
    else if (accept) parity_err_q <= !rd_fault && (^{mem_q[rd_idx], par_q[rd_idx]});
  end

  assign parity_err = parity_err_q;
`endif

  assign fetch_valid  = fetch_valid_q;
  assign fetch_fault  = fetch_fault_q;
  assign fetch_data   = fetch_data_q;
  assign dbg_done     = done_q;
  assign dbg_wr_ready = wr_ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_imem_banked_loader.sv
// Self-checking bench for imem_banked_loader (DEPTH=16) using a fetch scoreboard queue.
// Parity checks are compiled in when IMEM_PARITY_EN is defined.
module tb_imem_banked_loader;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_data;
  logic        dbg_start = 1'b0;
  logic [31:0] dbg_base = '0;
  logic [15:0] dbg_len = '0;
  logic        dbg_wr_valid = 1'b0;
  logic [31:0] dbg_wr_data = '0;
  logic        dbg_wr_ready, dbg_done, busy;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  imem_banked_loader #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .fetch_fault  (fetch_fault),
    .dbg_start    (dbg_start),
    .dbg_base     (dbg_base),
    .dbg_len      (dbg_len),
    .dbg_wr_valid (dbg_wr_valid),
    .dbg_wr_data  (dbg_wr_data),
    .dbg_wr_ready (dbg_wr_ready),
    .dbg_done     (dbg_done),
`ifdef IMEM_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [33:0] exp_q [$];
  logic [31:0] model [DEPTH];
  logic [31:0] beats [$];
  logic [33:0] e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every fetch_valid must match the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (fetch_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("fetch_fault", 64'(fetch_fault), 64'(e[32]));
        chk("fetch_data", 64'(fetch_data), 64'(e[31:0]));
`ifdef IMEM_PARITY_EN
        chk("parity_err", 64'(parity_err), 64'(e[33]));
`endif
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
  endtask

  // Count cycles busy stays high after reset release; called at the release negedge.
  task automatic wait_clear();
    int cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", 64'(cnt), 64'd16);
    chk("ready_after_clear", 64'(fetch_ready), 64'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic pe);
    int   t = 0;
    logic f;
    f = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    fetch_req  = 1'b1;
    fetch_addr = a;
    while (!fetch_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!fetch_ready) chk("fetch_ready_timeout", 64'd0, 64'd1);
    else exp_q.push_back({pe && !f, f, f ? NOP : model[a[5:2]]});
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic do_burst(input logic [31:0] base, input logic [15:0] len, input bit gap);
    int         t;
    int         n;
    logic [3:0] p;
    p = base[5:2];
    n = beats.size();
    dbg_start = 1'b1;
    dbg_base  = base;
    dbg_len   = len;
    @(negedge clk);
    dbg_start = 1'b0;
    chk("busy_in_load", 64'(busy), 64'd1);
    chk("fetch_ready_in_load", 64'(fetch_ready), 64'd0);
    for (int i = 0; i < n; i++) begin
      dbg_wr_valid = 1'b1;
      dbg_wr_data  = beats[i];
      t = 0;
      while (!dbg_wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!dbg_wr_ready) chk("wr_ready_timeout", 64'd0, 64'd1);
      chk("done_early", 64'(dbg_done), 64'd0);
      @(negedge clk);
      model[p] = beats[i];
      p = p + 4'd1;
      dbg_wr_valid = 1'b0;
      if (gap && i != n - 1) @(negedge clk);
    end
    chk("dbg_done_pulse", 64'(dbg_done), 64'd1);
    chk("wr_ready_after_load", 64'(dbg_wr_ready), 64'd0);
    @(negedge clk);
    chk("dbg_done_single", 64'(dbg_done), 64'd0);
    chk("busy_after_load", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);
    chk("rst_fetch_data", 64'(fetch_data), 64'd0);
    chk("rst_dbg_done", 64'(dbg_done), 64'd0);
    chk("rst_wr_ready", 64'(dbg_wr_ready), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    reset = 1'b0;
    wait_clear();

    do_fetch(32'h00, 1'b0);
    do_fetch(32'h3C, 1'b0);

    beats = {32'hCAFEBABE, 32'hDEADBEEF, 32'h12345678};
    do_burst(32'h08, 16'd3, 1'b1);
    do_fetch(32'h0C, 1'b0);
    do_fetch(32'h08, 1'b0);
    do_fetch(32'h10, 1'b0);

    // Burst wraps past the last word back to index 0.
    beats = {32'h11111111, 32'h22222222};
    do_burst(32'h3C, 16'd2, 1'b0);
    do_fetch(32'h3C, 1'b0);
    do_fetch(32'h00, 1'b0);
    do_fetch(32'h04, 1'b0);

    // Length zero loads one word; low base bits are ignored.
    beats = {32'h5A5A0001};
    do_burst(32'h17, 16'd0, 1'b0);
    do_fetch(32'h14, 1'b0);

    do_fetch(32'h02, 1'b0);
    do_fetch(32'h40, 1'b0);
    do_fetch(32'hFFFF_FFFC, 1'b0);
    do_fetch(32'h08, 1'b0);

    // Beats outside LOAD must not touch memory.
    dbg_wr_valid = 1'b1;
    dbg_wr_data  = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    dbg_wr_valid = 1'b0;
    do_fetch(32'h08, 1'b0);
    do_fetch(32'h18, 1'b0);

    // Fetches blocked during LOAD, then reset aborts the burst.
    dbg_start = 1'b1;
    dbg_base  = 32'h08;
    dbg_len   = 16'd3;
    @(negedge clk);
    dbg_start  = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h00;
    repeat (2) begin
      chk("ready_low_in_load", 64'(fetch_ready), 64'd0);
      @(negedge clk);
      chk("no_valid_in_load", 64'(fetch_valid), 64'd0);
    end
    dbg_wr_valid = 1'b1;
    dbg_wr_data  = 32'hAAAA5555;
    @(negedge clk);
    dbg_wr_valid = 1'b0;
    chk("no_done_mid_load", 64'(dbg_done), 64'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 64'(dbg_done), 64'd0);
    end
    chk("abort_busy", 64'(busy), 64'd1);
    fetch_req = 1'b0;
    reset = 1'b0;
    model_clear();
    wait_clear();
    chk("no_done_after_abort", 64'(dbg_done), 64'd0);
    do_fetch(32'h08, 1'b0);
    do_fetch(32'h0C, 1'b0);

`ifdef IMEM_PARITY_EN
    beats = {32'h0000000F, 32'h00000007, 32'h80000001};
    do_burst(32'h04, 16'd3, 1'b0);
    dut.mem_q[2] = dut.mem_q[2] ^ 32'h00000100;
    model[2] = model[2] ^ 32'h00000100;
    do_fetch(32'h08, 1'b1);
    do_fetch(32'h04, 1'b0);
    do_fetch(32'h0C, 1'b0);
    do_fetch(32'h0A, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
